// File: rtl/binary_bbox.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | binary_bbox: bounding box, white-pixel count and optional centroid       |
// | (macro BBOX_CENTROID_EN) of a binarised raster frame.                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module binary_bbox #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int MIN_PIXELS = 16
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSOF,
    input  logic        iDVAL,
    input  logic [11:0] iDATA,
    output logic [10:0] oX_MIN,
    output logic [10:0] oX_MAX,
    output logic [9:0]  oY_MIN,
    output logic [9:0]  oY_MAX,
    output logic [18:0] oCOUNT,
    output logic        oFOUND,
    output logic        oVALID,
`ifdef BBOX_CENTROID_EN
    output logic [10:0] oCX,
    output logic [9:0]  oCY,
`endif
    output logic        oBUSY
);

    localparam logic [10:0] c_COL_LAST = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  c_ROW_LAST = 10'(V_ACTIVE - 1);
    localparam logic [18:0] c_MIN_PIX  = 19'(MIN_PIXELS);
    localparam logic [18:0] c_CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2,
        DIV   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] col_q, col_d;
    logic [9:0]  row_q, row_d;
    logic [18:0] cnt_q, cnt_d;
    logic [10:0] xmin_q, xmin_d, xmax_q, xmax_d;
    logic [9:0]  ymin_q, ymin_d, ymax_q, ymax_d;
    logic [10:0] ox_min_q, ox_min_d, ox_max_q, ox_max_d;
    logic [9:0]  oy_min_q, oy_min_d, oy_max_q, oy_max_d;
    logic [18:0] ocount_q, ocount_d;
    logic        ofound_q, ofound_d;
    logic        ovalid_q, ovalid_d;
    logic        w_start, w_in_frame, w_load_out;
    logic        w_unused_data;

`ifdef BBOX_CENTROID_EN
    localparam logic [4:0] c_DIV_LAST = 5'd27;

    logic [27:0] sumx_q, sumx_d, sumy_q, sumy_d;
    logic [47:0] divx_q, divx_d, divy_q, divy_d;
    logic [47:0] w_stepx, w_stepy;
    logic [4:0]  step_q, step_d;
    logic [10:0] ocx_q, ocx_d;
    logic [9:0]  ocy_q, ocy_d;

    // One restoring step on {remainder[19:0], dividend/quotient[27:0]}.
    function automatic logic [47:0] div_step(input logic [47:0] rq, input logic [18:0] d);
        logic [19:0] tmp;
        tmp = {rq[46:28], rq[27]};
        if (rq[47] || (tmp >= {1'b0, d}))
            div_step = {tmp - {1'b0, d}, rq[26:0], 1'b1};
        else
            div_step = {tmp, rq[26:0], 1'b0};
    endfunction

    assign w_stepx = div_step(divx_q, cnt_q);
    assign w_stepy = div_step(divy_q, cnt_q);
    assign oCX     = ocx_q;
    assign oCY     = ocy_q;
`endif

    assign w_unused_data = ^iDATA[10:0];

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        cnt_d    = cnt_q;
        xmin_d   = xmin_q;
        xmax_d   = xmax_q;
        ymin_d   = ymin_q;
        ymax_d   = ymax_q;
        ox_min_d = ox_min_q;
        ox_max_d = ox_max_q;
        oy_min_d = oy_min_q;
        oy_max_d = oy_max_q;
        ocount_d = ocount_q;
        ofound_d = ofound_q;
        ovalid_d = 1'b0;
`ifdef BBOX_CENTROID_EN
        sumx_d   = sumx_q;
        sumy_d   = sumy_q;
        divx_d   = divx_q;
        divy_d   = divy_q;
        step_d   = step_q;
        ocx_d    = ocx_q;
        ocy_d    = ocy_q;
        w_load_out = (state_q == DIV) && (step_q == c_DIV_LAST);
`else
        w_load_out = (state_q == DONE);
`endif
        w_start    = iSOF && ((state_q == IDLE) || (state_q == ACCUM));
        w_in_frame = w_start || (state_q == ACCUM);

        if (w_start) begin
            state_d = ACCUM;
            col_d   = '0;
            row_d   = '0;
            cnt_d   = '0;
            xmin_d  = '1;
            ymin_d  = '1;
            xmax_d  = '0;
            ymax_d  = '0;
`ifdef BBOX_CENTROID_EN
            sumx_d  = '0;
            sumy_d  = '0;
`endif
        end

        // Pixel on the start-of-frame cycle is already pixel (0,0).
        if (w_in_frame && iDVAL) begin
            if (iDATA[11]) begin
                if (col_d < xmin_d) xmin_d = col_d;
                if (col_d > xmax_d) xmax_d = col_d;
                if (row_d < ymin_d) ymin_d = row_d;
                if (row_d > ymax_d) ymax_d = row_d;
                if (cnt_d != c_CNT_MAX) cnt_d = cnt_d + 19'd1;
`ifdef BBOX_CENTROID_EN
                sumx_d = sumx_d + {17'd0, col_d};
                sumy_d = sumy_d + {18'd0, row_d};
`endif
            end
            if (col_d == c_COL_LAST) begin
                col_d = '0;
                if (row_d == c_ROW_LAST) state_d = DONE;
                else                     row_d   = row_d + 10'd1;
            end else begin
                col_d = col_d + 11'd1;
            end
        end

`ifdef BBOX_CENTROID_EN
        if (state_q == DONE) begin
            divx_d  = {20'd0, sumx_q};
            divy_d  = {20'd0, sumy_q};
            step_d  = '0;
            state_d = DIV;
        end
        if (state_q == DIV) begin
            divx_d = w_stepx;
            divy_d = w_stepy;
            step_d = step_q + 5'd1;
        end
`endif

        if (w_load_out) begin
            state_d  = IDLE;
            ovalid_d = 1'b1;
            ocount_d = cnt_q;
            ofound_d = (cnt_q >= c_MIN_PIX);
            if (cnt_q == '0) begin
                ox_min_d = '0;
                ox_max_d = '0;
                oy_min_d = '0;
                oy_max_d = '0;
            end else begin
                ox_min_d = xmin_q;
                ox_max_d = xmax_q;
                oy_min_d = ymin_q;
                oy_max_d = ymax_q;
            end
`ifdef BBOX_CENTROID_EN
            ocx_d = (cnt_q == '0) ? '0 : w_stepx[10:0];
            ocy_d = (cnt_q == '0) ? '0 : w_stepy[9:0];
`endif
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            cnt_q    <= '0;
            xmin_q   <= '0;
            xmax_q   <= '0;
            ymin_q   <= '0;
            ymax_q   <= '0;
            ox_min_q <= '0;
            ox_max_q <= '0;
            oy_min_q <= '0;
            oy_max_q <= '0;
            ocount_q <= '0;
            ofound_q <= 1'b0;
            ovalid_q <= 1'b0;
`ifdef BBOX_CENTROID_EN
            sumx_q   <= '0;
            sumy_q   <= '0;
            divx_q   <= '0;
            divy_q   <= '0;
            step_q   <= '0;
            ocx_q    <= '0;
            ocy_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            xmin_q   <= xmin_d;
            xmax_q   <= xmax_d;
            ymin_q   <= ymin_d;
            ymax_q   <= ymax_d;
            ox_min_q <= ox_min_d;
            ox_max_q <= ox_max_d;
            oy_min_q <= oy_min_d;
            oy_max_q <= oy_max_d;
            ocount_q <= ocount_d;
            ofound_q <= ofound_d;
            ovalid_q <= ovalid_d;
`ifdef BBOX_CENTROID_EN
            sumx_q   <= sumx_d;
            sumy_q   <= sumy_d;
            divx_q   <= divx_d;
            divy_q   <= divy_d;
            step_q   <= step_d;
            ocx_q    <= ocx_d;
            ocy_q    <= ocy_d;
`endif
        end
    end

    assign oX_MIN = ox_min_q;
    assign oX_MAX = ox_max_q;
    assign oY_MIN = oy_min_q;
    assign oY_MAX = oy_max_q;
    assign oCOUNT = ocount_q;
    assign oFOUND = ofound_q;
    assign oVALID = ovalid_q;
    assign oBUSY  = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_binary_bbox.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_binary_bbox: directed scoreboard bench for binary_bbox on an 8x4      |
// | frame. Revision: 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_binary_bbox;

    localparam int H    = 8;
    localparam int V    = 4;
    localparam int MINP = 2;
`ifdef BBOX_CENTROID_EN
    localparam int LAT = 30;
`else
    localparam int LAT = 2;
`endif

    logic        iCLK = 1'b0;
    logic        iRST, iSOF, iDVAL;
    logic [11:0] iDATA;
    logic [10:0] oX_MIN, oX_MAX;
    logic [9:0]  oY_MIN, oY_MAX;
    logic [18:0] oCOUNT;
    logic        oFOUND, oVALID, oBUSY;
`ifdef BBOX_CENTROID_EN
    logic [10:0] oCX;
    logic [9:0]  oCY;
`endif

    binary_bbox #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(MINP)) dut (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iSOF   (iSOF),
        .iDVAL  (iDVAL),
        .iDATA  (iDATA),
        .oX_MIN (oX_MIN),
        .oX_MAX (oX_MAX),
        .oY_MIN (oY_MIN),
        .oY_MAX (oY_MAX),
        .oCOUNT (oCOUNT),
        .oFOUND (oFOUND),
        .oVALID (oVALID),
`ifdef BBOX_CENTROID_EN
        .oCX    (oCX),
        .oCY    (oCY),
`endif
        .oBUSY  (oBUSY)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    typedef struct {
        logic [10:0] xmin, xmax;
        logic [9:0]  ymin, ymax;
        logic [18:0] cnt;
        logic        found;
        logic [10:0] cx;
        logic [9:0]  cy;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t held;
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Results must appear only as scheduled and stay frozen in between.
    always @(negedge iCLK) begin
        if (!iRST) begin
            if (oVALID) begin
                chk("valid_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("valid_cycle", cyc, mon_e.cyc);
                    chk("x_min", oX_MIN, mon_e.xmin);
                    chk("x_max", oX_MAX, mon_e.xmax);
                    chk("y_min", oY_MIN, mon_e.ymin);
                    chk("y_max", oY_MAX, mon_e.ymax);
                    chk("count", oCOUNT, mon_e.cnt);
                    chk("found", oFOUND, mon_e.found);
                    chk("busy_at_valid", oBUSY, 0);
`ifdef BBOX_CENTROID_EN
                    chk("cx", oCX, mon_e.cx);
                    chk("cy", oCY, mon_e.cy);
`endif
                    held = mon_e;
                end
            end else begin
                chk("hold_x_min", oX_MIN, held.xmin);
                chk("hold_x_max", oX_MAX, held.xmax);
                chk("hold_y_min", oY_MIN, held.ymin);
                chk("hold_y_max", oY_MAX, held.ymax);
                chk("hold_count", oCOUNT, held.cnt);
                chk("hold_found", oFOUND, held.found);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge iCLK);
            iSOF  = 1'b0;
            iDVAL = 1'b0;
            iDATA = 12'hFFF;
        end
    endtask

    // Drives npix raster pixels (mask bit p = pixel p white), gap idle cycles
    // after each; when push is set the expected frame result is queued.
    task automatic send_frame(input logic [31:0] mask, input int npix, input int gap,
                              input bit sof, input bit push);
        exp_t e;
        int   n, sx, sy, c, r;
        n = 0; sx = 0; sy = 0;
        e.xmin = '1; e.xmax = '0; e.ymin = '1; e.ymax = '0;
        for (int p = 0; p < npix; p++) begin
            c = p % H;
            r = p / H;
            @(negedge iCLK);
            iSOF  = sof && (p == 0);
            iDVAL = 1'b1;
            iDATA = {mask[p], 11'($urandom)};
            if (mask[p]) begin
                n++;
                sx += c;
                sy += r;
                if (11'(c) < e.xmin) e.xmin = 11'(c);
                if (11'(c) > e.xmax) e.xmax = 11'(c);
                if (10'(r) < e.ymin) e.ymin = 10'(r);
                if (10'(r) > e.ymax) e.ymax = 10'(r);
            end
            if (push && (p == npix - 1)) begin
                e.cnt   = 19'(n);
                e.found = (n >= MINP);
                if (n == 0) begin
                    e.xmin = '0; e.xmax = '0; e.ymin = '0; e.ymax = '0;
                    e.cx = '0; e.cy = '0;
                end else begin
                    e.cx = 11'(sx / n);
                    e.cy = 10'(sy / n);
                end
                e.cyc = cyc + LAT;
                sb.push_back(e);
            end
            for (int g = 0; g < gap; g++) begin
                @(negedge iCLK);
                iSOF  = 1'b0;
                iDVAL = 1'b0;
                iDATA = 12'hFFF;
            end
        end
    endtask

    initial begin
        held  = '{default: '0};
        iRST  = 1'b1;
        iSOF  = 1'b0;
        iDVAL = 1'b0;
        iDATA = 12'h000;
        #2;
        chk("rst_x_max", oX_MAX, 0);
        chk("rst_count", oCOUNT, 0);
        chk("rst_valid", oVALID, 0);
        chk("rst_busy",  oBUSY,  0);
        repeat (3) @(negedge iCLK);
        iRST = 1'b0;
        idle(2);

        // Pixels without a start-of-frame are ignored.
        send_frame(32'hFFFF_FFFF, 5, 0, 1'b0, 1'b0);
        idle(3);
        chk("idle_busy", oBUSY, 0);

        send_frame(32'h0000_0000, 32, 0, 1'b1, 1'b1);
        idle(LAT + 3);

        // Whites at (2,1),(5,3),(6,1); then a start pulse while in DONE.
        send_frame(32'h2000_4400, 32, 0, 1'b1, 1'b1);
        @(negedge iCLK);
        iSOF  = 1'b1;
        iDVAL = 1'b0;
        idle(LAT + 3);

        // Opposite corners, exactly MIN_PIXELS whites, gapped input.
        send_frame(32'h8000_0001, 32, 1, 1'b1, 1'b1);
        idle(LAT + 3);

        send_frame(32'h8000_0000, 32, 3, 1'b1, 1'b1);
        idle(LAT + 3);

        // Restart after 10 pixels: partial frame must vanish.
        send_frame(32'h0000_0208, 10, 0, 1'b1, 1'b0);
        send_frame(32'h0000_0001, 32, 0, 1'b1, 1'b1);
        idle(LAT + 3);

        // Reset mid-frame.
        send_frame(32'h0000_0F0F, 12, 0, 1'b1, 1'b0);
        chk("busy_mid_frame", oBUSY, 1);
        @(negedge iCLK);
        #1;
        iRST  = 1'b1;
        iSOF  = 1'b0;
        iDVAL = 1'b0;
        held  = '{default: '0};
        #1;
        chk("midrst_x_min", oX_MIN, 0);
        chk("midrst_y_max", oY_MAX, 0);
        chk("midrst_count", oCOUNT, 0);
        chk("midrst_found", oFOUND, 0);
        chk("midrst_busy",  oBUSY,  0);
        repeat (2) @(negedge iCLK);
        iRST = 1'b0;
        send_frame(32'hFFFF_FFFF, 8, 0, 1'b0, 1'b0);
        idle(LAT + 3);
        send_frame(32'h0300_8010, 32, 0, 1'b1, 1'b1);

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge iCLK);
        idle(3);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/binary_bbox.md
BINARY_BBOX -- requirements
Module: binary_bbox

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 SHALL have parameter MIN_PIXELS, default 16: minimum white-pixel count for a detected object.
REQ-004 SHALL have port iCLK, input, 1: sole clock; all logic on rising edge.
REQ-005 SHALL have port iRST, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port iSOF, input, 1: one-cycle start-of-frame pulse, asserted with or before the first pixel.
REQ-007 SHALL have port iDVAL, input, 1: qualifies iDATA.
REQ-008 SHALL have port iDATA, input, 12: binarised pixel, 0 or 4095.
REQ-009 SHALL have ports oX_MIN and oX_MAX, output, 11 each: bounding-box columns.
REQ-010 SHALL have ports oY_MIN and oY_MAX, output, 10 each: bounding-box rows.
REQ-011 SHALL have port oCOUNT, output, 19: white-pixel count of the last completed frame.
REQ-012 SHALL have port oFOUND, output, 1: oCOUNT >= MIN_PIXELS.
REQ-013 SHALL have port oVALID, output, 1: one-cycle pulse when results update.
REQ-014 SHALL have port oBUSY, output, 1: high outside IDLE.

Function
REQ-015 SHALL classify a pixel as white when iDVAL=1 and iDATA[11]=1; no other iDATA bit is examined.
REQ-016 SHALL implement states IDLE, ACCUM and DONE (plus DIV when so configured); iSOF in IDLE -> ACCUM with column=0, row=0, count=0, min registers at all-ones and max registers at 0.
REQ-017 SHALL, in ACCUM, advance the column on each iDVAL cycle, wrap at H_ACTIVE-1 to 0, and increment the row on wrap; cycles with iDVAL=0 change nothing.
REQ-018 SHALL, for each white pixel, update min/max X/Y with the current column/row and increment count; updates take effect the cycle after the sample.
REQ-019 SHALL count pixels of the same cycle as iSOF in IDLE as pixel (0,0).
REQ-020 SHALL enter DONE on the cycle after sampling pixel (H_ACTIVE-1, V_ACTIVE-1).
REQ-021 SHALL, in DONE, register all outputs and pulse oVALID; oVALID is high 2 cycles after the last pixel is sampled; DONE -> IDLE.
REQ-022 SHALL report X_MIN=Y_MIN=0 and X_MAX=Y_MAX=0 when count=0, with oFOUND=0.
REQ-023 SHALL, on iSOF while in ACCUM, discard the partial frame, reinitialise as in REQ-016 and stay in ACCUM with no oVALID; outputs keep their previous values.
REQ-024 SHALL ignore iSOF in DONE and in DIV.
REQ-025 SHALL saturate count at 2^19-1.
REQ-026 SHALL ignore iDVAL in IDLE when iSOF=0.
REQ-027 SHALL hold outputs stable between oVALID pulses.

Reset
REQ-028 SHALL, while iRST=1, force state to IDLE and all outputs and counters to 0, regardless of iCLK.
REQ-029 SHALL, when reset is asserted mid-frame, discard the frame with no oVALID; after release, wait for the next iSOF.

Configuration
REQ-030 SHALL use macro BBOX_CENTROID_EN; when defined, SHALL add outputs oCX (11 bits) and oCY (10 bits), the floor of the sum of white X / count and of white Y / count, accumulated in 28-bit sums.
REQ-031 SHALL, when BBOX_CENTROID_EN is defined, go DONE -> DIV and run two parallel 28-cycle restoring dividers; all outputs, including oVALID, are registered together at DIV exit, 30 cycles after the last pixel; count=0 gives oCX=oCY=0.
REQ-032 SHALL, when BBOX_CENTROID_EN is undefined, omit the oCX/oCY ports, the sums and the DIV state, with timing as in REQ-021.

Verification (H_ACTIVE=8, V_ACTIVE=4, MIN_PIXELS=2)
REQ-033 SHALL check: all-zero frame -> one oVALID, oCOUNT=0, oFOUND=0, box all 0.
REQ-034 SHALL check: white at (2,1),(5,3),(6,1) -> X 2..6, Y 1..3, oCOUNT=3, oFOUND=1; with macro, oCX=4, oCY=1.
REQ-035 SHALL check: a single white pixel at (7,3) with iDVAL gaps of 3 cycles between every pixel -> box 7..7/3..3, oCOUNT=1, oFOUND=0; oVALID exactly 2 cycles (or 30 cycles with macro) after the last pixel.
REQ-036 SHALL check: iSOF reissued after 10 pixels, then a full frame with white at (0,0) -> only one oVALID; result box 0..0/0..0, count=1.
REQ-037 SHALL check: iRST pulsed mid-frame -> outputs 0, oBUSY=0, no oVALID until a full frame follows the next iSOF.
